sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Shares the single board SRAM port among three requesters: the flash boot loader, the CPU MEM stage (data) and the CPU IF stage (instruction fetch).
- Fixed priority with an anti-starvation guard for instruction fetch.
- Runs each granted access as a multi-cycle SRAM read or write, returns data with a one-cycle ack, and raises a pipeline stall while CPU requests are outstanding.
- Sits between the CPU/boot logic and the SRAM pins, and replaces ad-hoc phase counting in the memory path.

Parameters:
- ACCESS_CYCLES, 4, cycles per SRAM access including setup and hold (legal values 3..15).
- STARVE_MAX, 3, number of consecutive data grants allowed while an instruction request waits before instruction fetch is forced.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- boot_req_i  in  1  boot requester access request (level)
- boot_we_i  in  1  boot access is a write (1) or read (0)
- boot_addr_i  in  16  boot word address
- boot_wdata_i  in  16  boot write data
- boot_ack_o  out  1  boot access complete (1-cycle pulse)
- d_req_i  in  1  data request
- d_we_i  in  1  data write (1) or read (0)
- d_addr_i  in  16  data address
- d_wdata_i  in  16  data write data
- d_ack_o  out  1  data access complete (pulse)
- i_req_i  in  1  instruction fetch request (always a read)
- i_addr_i  in  16  fetch address
- i_ack_o  out  1  fetch complete (pulse)
- rdata_o  out  16  read data; valid in the ack cycle
- stall_o  out  1  pipeline pause request
- grant_o  out  2  current owner: 0 none, 1 boot, 2 data, 3 inst
- ram_addr_o  out  16  SRAM address
- ram_wdata_o  out  16  SRAM write data
- ram_rdata_i  in  16  SRAM read data
- ram_data_oe_o  out  1  drive SRAM data bus (write only)
- ram_ce_n_o  out  1  SRAM chip enable, active-low
- ram_oe_n_o  out  1  SRAM output enable, active-low
- ram_we_n_o  out  1  SRAM write enable, active-low

Behaviour:
- Reset (rst=0, asynchronous) values:
  - State IDLE; counter 0; starve counter 0.
  - All acks 0; grant_o 0; rdata_o 0.
  - ram_ce_n_o, ram_oe_n_o, ram_we_n_o = 1; ram_data_oe_o 0; ram_addr_o 0; ram_wdata_o 0.
  - Reset mid-access aborts immediately with no ack.
- States: IDLE, ACCESS, DONE.
- IDLE: arbitration on sampled request levels.
  - Priority is boot > data > inst.
  - If i_req_i waits and the starve counter equals STARVE_MAX, inst wins over data (never over boot).
  - Winner's addr/we/wdata are latched into internal registers and grant_o is set; go to ACCESS with counter 0.
  - No request: stay in IDLE, grant_o 0.
- ACCESS: counter runs 0..ACCESS_CYCLES-1.
  - ram_ce_n_o is 0 for all access cycles.
  - Address and write data come from the latched registers and stay stable throughout.
  - Write: ram_data_oe_o=1 for all access cycles; ram_we_n_o=0 for counter 1..ACCESS_CYCLES-2.
  - Read: ram_oe_n_o=0 for counter 1..ACCESS_CYCLES-1; ram_rdata_i is latched into rdata_o at counter ACCESS_CYCLES-1.
  - After the last cycle, go to DONE.
- DONE: one cycle.
  - Pulse the owner's ack; all SRAM strobes are deasserted.
  - grant_o stays at the owner value; go to IDLE next cycle (back-to-back accesses are separated by 1 IDLE cycle).
  - Starve counter: increments on a data completion while i_req_i=1; clears on an inst completion; saturates at STARVE_MAX.
- Latency: a request seen in IDLE cycle T is acked in cycle T+ACCESS_CYCLES+1.
- rdata_o holds its value until the next read latch. Writes do not change rdata_o.
- Handshake:
  - A requester holds req, addr, we and wdata stable until its ack.
  - A request is latched at grant; deasserting req mid-access does not abort, and the ack is still issued.
  - req high in the ack cycle counts as a new request.
- stall_o = (d_req_i & ~d_ack_o) | (i_req_i & ~i_ack_o) | boot_req_i. This is combinational from registered acks.
- Simultaneous events: all three requesting in IDLE → boot granted; data and inst together → data, unless the starve counter equals STARVE_MAX.
- Address is passed through unmodified (word addressing); 0xFFFF is legal, with no wrap logic.

Test Plan:
- Reset, then i_req_i=1, i_addr_i=0x0010, SRAM model returns 0xA5A5 → i_ack_o pulses 5 cycles after the request with rdata_o=0xA5A5; ram_we_n_o stays 1; grant_o=3 during the access.
- d_req_i=1, d_we_i=1, d_addr_i=0x8000, d_wdata_i=0x1234 → ram_we_n_o low for exactly 2 cycles with ram_addr_o=0x8000 and ram_wdata_o=0x1234; d_ack_o pulses once; SRAM model location 0x8000=0x1234.
- boot, data and inst requests all asserted in the same cycle → grant order boot, data, inst; each ack 6 cycles apart; stall_o=1 until the final i_ack_o.
- d_req_i held high continuously with i_req_i=1 → after 3 data grants, inst is granted; the starve counter then returns to 0.
- rst driven low during ACCESS counter 2 of a write → ram_we_n_o and ram_ce_n_o go to 1 immediately, with no ack; after release, a new request completes normally.
- d_req_i dropped at counter 1 of a read → d_ack_o still pulses and rdata_o is updated; no second access is started.

Source files
------------

// File: rtl/sram_arbiter.sv
// Three-way arbiter for the board SRAM port: boot > data > inst, with a starvation
// guard that lets instruction fetch win after STARVE_MAX data grants.
module sram_arbiter #(
  parameter int ACCESS_CYCLES = 4,
  parameter int STARVE_MAX    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        boot_req_i,
  input  logic        boot_we_i,
  input  logic [15:0] boot_addr_i,
  input  logic [15:0] boot_wdata_i,
  output logic        boot_ack_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [15:0] d_addr_i,
  input  logic [15:0] d_wdata_i,
  output logic        d_ack_o,
  input  logic        i_req_i,
  input  logic [15:0] i_addr_i,
  output logic        i_ack_o,
  output logic [15:0] rdata_o,
  output logic        stall_o,
  output logic [1:0]  grant_o,
  output logic [15:0] ram_addr_o,
  output logic [15:0] ram_wdata_o,
  input  logic [15:0] ram_rdata_i,
  output logic        ram_data_oe_o,
  output logic        ram_ce_n_o,
  output logic        ram_oe_n_o,
  output logic        ram_we_n_o
);

  // state    | meaning
  // S_IDLE   | arbitrate on sampled request levels, grant_o 0
  // S_ACCESS | SRAM cycle, counter 0..ACCESS_CYCLES-1
  // S_DONE   | one-cycle ack to the owner, strobes released
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  localparam logic [3:0] LAST   = 4'(ACCESS_CYCLES - 1);
  localparam logic [3:0] WE_END = 4'(ACCESS_CYCLES - 2);
  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_BOOT = 2'd1;
  localparam logic [1:0] OWN_DATA = 2'd2;
  localparam logic [1:0] OWN_INST = 2'd3;

  state_t        r_state, w_state_nxt;
  logic [3:0]    r_cnt;
  logic [SW-1:0] r_starve;
  logic [1:0]    r_owner;
  logic          r_we;
  logic [15:0]   r_addr;
  logic [15:0]   r_wdata;
  logic [15:0]   r_rdata;
  logic [1:0]    w_win;
  logic          w_acc;
  logic          w_done;

  always_comb begin
    w_state_nxt = r_state;
    w_win       = OWN_NONE;
    case (r_state)
      S_IDLE: begin
        if (boot_req_i)
          w_win = OWN_BOOT;
        else if (i_req_i && (r_starve == SMAX || !d_req_i))
          w_win = OWN_INST;
        else if (d_req_i)
          w_win = OWN_DATA;
        if (w_win != OWN_NONE)
          w_state_nxt = S_ACCESS;
      end
      S_ACCESS: if (r_cnt == LAST) w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_starve <= '0;
      r_owner  <= OWN_NONE;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (w_win != OWN_NONE) begin
            r_owner <= w_win;
            r_cnt   <= '0;
            case (w_win)
              OWN_BOOT: begin
                r_addr  <= boot_addr_i;
                r_we    <= boot_we_i;
                r_wdata <= boot_wdata_i;
              end
              OWN_DATA: begin
                r_addr  <= d_addr_i;
                r_we    <= d_we_i;
                r_wdata <= d_wdata_i;
              end
              default: begin
                r_addr <= i_addr_i;
                r_we   <= 1'b0;
              end
            endcase
          end
        end
        S_ACCESS: begin
          if (r_cnt == LAST) begin
            r_cnt <= '0;
            if (!r_we) r_rdata <= ram_rdata_i;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_DONE: begin
          r_owner <= OWN_NONE;
          // Fetch starvation only accrues while a fetch is actually waiting
          if (r_owner == OWN_DATA && i_req_i && r_starve != SMAX)
            r_starve <= r_starve + 1'b1;
          else if (r_owner == OWN_INST)
            r_starve <= '0;
        end
        default: ;
      endcase
    end
  end

  assign w_acc  = (r_state == S_ACCESS);
  assign w_done = (r_state == S_DONE);

  assign ram_addr_o    = r_addr;
  assign ram_wdata_o   = r_wdata;
  assign ram_ce_n_o    = ~w_acc;
  assign ram_data_oe_o = w_acc & r_we;
  assign ram_we_n_o    = ~(w_acc & r_we & (r_cnt >= 4'd1) & (r_cnt <= WE_END));
  assign ram_oe_n_o    = ~(w_acc & ~r_we & (r_cnt >= 4'd1));

  assign boot_ack_o = w_done & (r_owner == OWN_BOOT);
  assign d_ack_o    = w_done & (r_owner == OWN_DATA);
  assign i_ack_o    = w_done & (r_owner == OWN_INST);
  assign grant_o    = r_owner;
  assign rdata_o    = r_rdata;

  assign stall_o = (d_req_i & ~d_ack_o) | (i_req_i & ~i_ack_o) | boot_req_i;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a simple SRAM array model on the pins.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        boot_req_i, boot_we_i;
  logic [15:0] boot_addr_i, boot_wdata_i;
  logic        boot_ack_o;
  logic        d_req_i, d_we_i;
  logic [15:0] d_addr_i, d_wdata_i;
  logic        d_ack_o;
  logic        i_req_i;
  logic [15:0] i_addr_i;
  logic        i_ack_o;
  logic [15:0] rdata_o;
  logic        stall_o;
  logic [1:0]  grant_o;
  logic [15:0] ram_addr_o, ram_wdata_o, ram_rdata_i;
  logic        ram_data_oe_o, ram_ce_n_o, ram_oe_n_o, ram_we_n_o;

  logic [15:0] mem [0:65535];
  int n_cmp = 0;
  int n_err = 0;
  bit chk_stall = 0;
  int stall_gaps = 0;

  always #5 clk = ~clk;

  sram_arbiter #(.ACCESS_CYCLES(4), .STARVE_MAX(3)) dut (
    .clk(clk), .rst(rst),
    .boot_req_i(boot_req_i), .boot_we_i(boot_we_i), .boot_addr_i(boot_addr_i),
    .boot_wdata_i(boot_wdata_i), .boot_ack_o(boot_ack_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_ack_o(d_ack_o),
    .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_ack_o(i_ack_o),
    .rdata_o(rdata_o), .stall_o(stall_o), .grant_o(grant_o),
    .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i),
    .ram_data_oe_o(ram_data_oe_o), .ram_ce_n_o(ram_ce_n_o),
    .ram_oe_n_o(ram_oe_n_o), .ram_we_n_o(ram_we_n_o)
  );

  always @(posedge clk)
    if (!ram_ce_n_o && !ram_we_n_o && ram_data_oe_o) mem[ram_addr_o] <= ram_wdata_o;
  assign ram_rdata_i = (!ram_ce_n_o && !ram_oe_n_o) ? mem[ram_addr_o] : 16'h0000;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // who: 1 boot, 2 data, 3 inst, 0 none within budget; lat counts negedges
  task automatic wait_any_ack(input int budget, output int who, output int lat);
    who = 0;
    lat = 0;
    while (who == 0 && lat < budget) begin
      @(negedge clk);
      lat++;
      if (boot_ack_o) who = 1;
      else if (d_ack_o) who = 2;
      else if (i_ack_o) who = 3;
      else if (chk_stall && !stall_o) stall_gaps++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int who, lat, we_low, ce_low;
    for (int a = 0; a < 65536; a++) mem[a] = 16'h0000;
    mem[16'h0010] = 16'hA5A5;
    mem[16'h0100] = 16'h1111;
    mem[16'h0200] = 16'h2222;
    mem[16'h0300] = 16'h3333;
    mem[16'h0400] = 16'h4444;
    mem[16'h0500] = 16'h5555;
    mem[16'hFFFF] = 16'h5A5A;

    rst = 1'b0;
    boot_req_i = 0; boot_we_i = 0; boot_addr_i = 0; boot_wdata_i = 0;
    d_req_i = 0; d_we_i = 0; d_addr_i = 0; d_wdata_i = 0;
    i_req_i = 0; i_addr_i = 0;
    repeat (3) @(negedge clk);
    check_eq("rst_grant", grant_o, 2'd0);
    check_eq("rst_strobes", {ram_ce_n_o, ram_oe_n_o, ram_we_n_o, ram_data_oe_o}, 4'b1110);
    check_eq("rst_addr_wdata", {ram_addr_o, ram_wdata_o}, 32'h0);
    check_eq("rst_rdata", rdata_o, 16'h0);
    check_eq("rst_acks", {boot_ack_o, d_ack_o, i_ack_o}, 3'b000);
    rst = 1'b1;
    @(negedge clk);

    // inst read
    i_req_i = 1; i_addr_i = 16'h0010;
    we_low = 0;
    @(negedge clk);
    check_eq("t1_grant", grant_o, 2'd3);
    check_eq("t1_stall", stall_o, 1'b1);
    if (!ram_we_n_o) we_low++;
    wait_any_ack(20, who, lat);
    i_req_i = 0;
    check_eq("t1_who", who, 3);
    check_eq("t1_lat", lat + 1, 5);
    check_eq("t1_rdata", rdata_o, 16'hA5A5);
    check_eq("t1_we_n_high", we_low, 0);

    // data write
    @(negedge clk);
    d_req_i = 1; d_we_i = 1; d_addr_i = 16'h8000; d_wdata_i = 16'h1234;
    we_low = 0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (!ram_we_n_o) we_low++;
      if (c == 2) begin
        check_eq("t2_addr", ram_addr_o, 16'h8000);
        check_eq("t2_wdata", ram_wdata_o, 16'h1234);
        check_eq("t2_oe_drive", ram_data_oe_o, 1'b1);
      end
    end
    wait_any_ack(20, who, lat);
    d_req_i = 0; d_we_i = 0;
    check_eq("t2_who", who, 2);
    check_eq("t2_lat", lat + 4, 5);
    check_eq("t2_we_cycles", we_low, 2);
    check_eq("t2_mem", mem[16'h8000], 16'h1234);
    check_eq("t2_rdata_kept", rdata_o, 16'hA5A5);
    wait_any_ack(6, who, lat);
    check_eq("t2_single_ack", who, 0);

    // all three at once
    boot_req_i = 1; boot_we_i = 0; boot_addr_i = 16'h0100;
    d_req_i = 1; d_we_i = 0; d_addr_i = 16'h0200;
    i_req_i = 1; i_addr_i = 16'h0300;
    chk_stall = 1; stall_gaps = 0;
    @(negedge clk);
    check_eq("t3_grant_boot", grant_o, 2'd1);
    wait_any_ack(20, who, lat);
    boot_req_i = 0;
    check_eq("t3_first", who, 1);
    check_eq("t3_boot_rdata", rdata_o, 16'h1111);
    wait_any_ack(20, who, lat);
    d_req_i = 0;
    check_eq("t3_second", who, 2);
    check_eq("t3_gap_d", lat, 6);
    check_eq("t3_d_rdata", rdata_o, 16'h2222);
    wait_any_ack(20, who, lat);
    i_req_i = 0;
    chk_stall = 0;
    check_eq("t3_third", who, 3);
    check_eq("t3_gap_i", lat, 6);
    check_eq("t3_i_rdata", rdata_o, 16'h3333);
    check_eq("t3_stall_held", stall_gaps, 0);
    @(negedge clk);
    check_eq("t3_stall_off", stall_o, 1'b0);

    // starvation guard
    d_req_i = 1; d_we_i = 0; d_addr_i = 16'h0400;
    i_req_i = 1; i_addr_i = 16'h0500;
    for (int k = 0; k < 3; k++) begin
      wait_any_ack(20, who, lat);
      check_eq($sformatf("t4_data_%0d", k), who, 2);
    end
    wait_any_ack(20, who, lat);
    d_req_i = 0; i_req_i = 0;
    check_eq("t4_inst_forced", who, 3);
    check_eq("t4_inst_rdata", rdata_o, 16'h5555);
    repeat (2) @(negedge clk);
    d_req_i = 1; i_req_i = 1;
    wait_any_ack(20, who, lat);
    d_req_i = 0;
    check_eq("t4_starve_cleared", who, 2);
    wait_any_ack(20, who, lat);
    i_req_i = 0;
    check_eq("t4_inst_after", who, 3);

    // address 0xFFFF
    @(negedge clk);
    i_req_i = 1; i_addr_i = 16'hFFFF;
    @(negedge clk);
    check_eq("t5_addr_max", ram_addr_o, 16'hFFFF);
    wait_any_ack(20, who, lat);
    i_req_i = 0;
    check_eq("t5_rdata", rdata_o, 16'h5A5A);

    // reset in the middle of a write
    @(negedge clk);
    d_req_i = 1; d_we_i = 1; d_addr_i = 16'h1000; d_wdata_i = 16'hBEEF;
    repeat (3) @(negedge clk);
    check_eq("t6_we_low_cnt2", {ram_ce_n_o, ram_we_n_o}, 2'b00);
    rst = 1'b0;
    #1;
    check_eq("t6_abort_strobes", {ram_ce_n_o, ram_we_n_o, ram_data_oe_o}, 3'b110);
    check_eq("t6_abort_grant", grant_o, 2'd0);
    d_req_i = 0; d_we_i = 0;
    wait_any_ack(3, who, lat);
    check_eq("t6_no_ack", who, 0);
    rst = 1'b1;
    @(negedge clk);
    d_req_i = 1; d_addr_i = 16'h8000;
    wait_any_ack(20, who, lat);
    d_req_i = 0;
    check_eq("t6_after_who", who, 2);
    check_eq("t6_after_lat", lat, 5);
    check_eq("t6_after_rdata", rdata_o, 16'h1234);

    // data request dropped at counter 1
    @(negedge clk);
    d_req_i = 1; d_we_i = 0; d_addr_i = 16'h0200;
    repeat (2) @(negedge clk);
    d_req_i = 0;
    wait_any_ack(20, who, lat);
    check_eq("t7_who", who, 2);
    check_eq("t7_lat", lat + 2, 5);
    check_eq("t7_rdata", rdata_o, 16'h2222);
    ce_low = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (!ram_ce_n_o) ce_low++;
    end
    check_eq("t7_no_second", ce_low, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
